// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Scan controller for a 4-digit 7-segment timer display. Steps the external
//   4:1 digit mux through digits 3,2,1,0 (sel), samples the mux output at the
//   end of a dead-time window, then lights one anode with the decoded segments.
//   Leading zeros can be blanked; frame_done pulses once per full 4-digit scan.
//
//   Each slot is DIV cycles: BLANK dead cycles (all anodes off) followed by
//   DIV-BLANK lit cycles. The dead time doubles as settling time for the mux.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous reset, active-low
//   en         in   1  scan enable; 0 = display off, scan restarts at digit 3
//   blank_lz   in   1  1 = blank leading zeros (digit 0 always shown)
//   digit_in   in   4  mux output for the digit selected by sel
//   sel        out  2  digit select to the mux, 3 = most significant
//   an         out  4  anode enables, active-low, one-hot-low when lit
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   frame_done out  1  one-cycle pulse, high in the first cycle of each new
//                      frame (the cycle after digit 0's slot ends)
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] digit_in,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] C_SHOW_LAST  = CW'(DIV - 1);
    localparam logic [6:0]    C_SEG_OFF    = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    // Architectural state
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_sel;
    logic          r_nz;
    logic [3:0]    r_dq;

    // Registered outputs
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_fd;

    // Next-state values
    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_sel_nxt;
    logic          w_nz_nxt;
    logic [3:0]    w_dq_nxt;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_fd_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state logic. Outputs are derived from the *next* state so the
    // registered an/seg line up with the state they describe, cycle for cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_nz_nxt    = r_nz;
        w_dq_nxt    = r_dq;
        w_fd_nxt    = 1'b0;
        w_an_nxt    = 4'b1111;
        w_seg_nxt   = C_SEG_OFF;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_sel_nxt = 2'd3;
                w_nz_nxt  = 1'b0;
                if (en) w_state_nxt = S_BLANK;
            end
            S_BLANK: begin
                w_cnt_nxt = r_cnt + CW'(1);
                // Sample late in the dead time so the mux has settled.
                if (r_cnt == C_BLANK_LAST) begin
                    w_dq_nxt    = digit_in;
                    w_nz_nxt    = r_nz | (digit_in != 4'd0);
                    w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (r_cnt == C_SHOW_LAST) begin
                    w_cnt_nxt   = '0;
                    w_sel_nxt   = r_sel - 2'd1;
                    w_state_nxt = S_BLANK;
                    if (r_sel == 2'd0) begin
                        w_fd_nxt = 1'b1;
                        w_nz_nxt = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_sel_nxt   = 2'd3;
                w_nz_nxt    = 1'b0;
            end
        endcase

        // Disable wins over everything, including a pending frame wrap.
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_sel_nxt   = 2'd3;
            w_nz_nxt    = 1'b0;
            w_fd_nxt    = 1'b0;
        end

        if (w_state_nxt == S_SHOW) begin
            w_an_nxt = ~(4'b0001 << w_sel_nxt);
            if (!blank_lz || w_nz_nxt || (w_sel_nxt == 2'd0))
                w_seg_nxt = hex7(w_dq_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= 2'd3;
            r_nz    <= 1'b0;
            r_dq    <= 4'd0;
            r_an    <= 4'b1111;
            r_seg   <= C_SEG_OFF;
            r_fd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_nz    <= w_nz_nxt;
            r_dq    <= w_dq_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
            r_fd    <= w_fd_nxt;
        end
    end

    assign sel        = r_sel;
    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_done = r_fd;

endmodule
